// File: rtl/board_action_ctrl.sv
// Player-action sequencer for the board-cell RAM: cursor, flag/reveal read-modify-write,
// flags-left / revealed-count bookkeeping and sticky game_over / win status.
//
// state  | meaning
// S_IDLE | waiting; moves applied, flag/reveal accepted
// S_RD   | action latched, ram_addr presented
// S_WT   | RAM samples the address
// S_EXEC | ram_rdata valid; decide and write the cell if it changes
// S_DONE | action_done pulse; busy drops next cycle
module board_action_ctrl #(
    parameter int COLS   = 8,
    parameter int ROWS   = 8,
    parameter int MINES  = 10,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              mv_up,
    input  logic              mv_dn,
    input  logic              mv_lf,
    input  logic              mv_rt,
    input  logic              req_flag,
    input  logic              req_reveal,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    output logic [3:0]        cur_x,
    output logic [3:0]        cur_y,
    output logic              busy,
    output logic              action_done,
    output logic [7:0]        flags_left,
    output logic              game_over,
    output logic              win
);

    localparam logic [3:0] X_MAX      = 4'(COLS - 1);
    localparam logic [3:0] Y_MAX      = 4'(ROWS - 1);
    localparam logic [8:0] SAFE_CELLS = 9'(ROWS * COLS - MINES);
    localparam logic [7:0] FLAGS_INIT = 8'(MINES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_EXEC,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic       clear;
    logic       accept;
    logic       move_ok;
    logic       act_reveal;
    logic [8:0] revealed_cnt;
    logic       cell_change;
    logic [7:0] cell_new;

    assign clear   = reset | new_game;
    assign accept  = (state == S_IDLE) && !game_over && !win && (req_flag || req_reveal);
    // An accepted action freezes the cursor so it uses the pre-move position.
    assign move_ok = (state == S_IDLE) && !accept;

    assign ram_addr = ADDR_W'(32'(cur_y) * 32'(COLS) + 32'(cur_x));

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RD;
            S_RD:    state_nxt = S_WT;
            S_WT:    state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        action_done = (state == S_DONE);
        cell_change = 1'b0;
        cell_new    = ram_rdata;
        if (act_reveal) begin
            if (!ram_rdata[5] && !ram_rdata[6]) begin
                cell_change = 1'b1;
                cell_new[6] = 1'b1;
            end
        end else if (!ram_rdata[6]) begin
            if (ram_rdata[5]) begin
                cell_change = 1'b1;
                cell_new[5] = 1'b0;
            end else if (flags_left != 8'd0) begin
                cell_change = 1'b1;
                cell_new[5] = 1'b1;
            end
        end
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (state == S_EXEC && cell_change) begin
            ram_we    = 1'b1;
            ram_wdata = cell_new;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cur_x        <= 4'd0;
            cur_y        <= 4'd0;
            act_reveal   <= 1'b0;
            flags_left   <= FLAGS_INIT;
            revealed_cnt <= 9'd0;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else begin
            if (accept) begin
                act_reveal <= req_reveal;
            end
            if (move_ok) begin
                if (mv_rt && !mv_lf && cur_x != X_MAX) begin
                    cur_x <= cur_x + 4'd1;
                end else if (mv_lf && !mv_rt && cur_x != 4'd0) begin
                    cur_x <= cur_x - 4'd1;
                end
                if (mv_dn && !mv_up && cur_y != Y_MAX) begin
                    cur_y <= cur_y + 4'd1;
                end else if (mv_up && !mv_dn && cur_y != 4'd0) begin
                    cur_y <= cur_y - 4'd1;
                end
            end
            // Bookkeeping rides on the write strobe: no write means nothing changed.
            if (ram_we) begin
                if (act_reveal) begin
                    if (ram_rdata[7]) begin
                        game_over <= 1'b1;
                    end else begin
                        revealed_cnt <= revealed_cnt + 9'd1;
                        if (revealed_cnt + 9'd1 == SAFE_CELLS) begin
                            win <= 1'b1;
                        end
                    end
                end else if (ram_rdata[5]) begin
                    flags_left <= flags_left + 8'd1;
                end else begin
                    flags_left <= flags_left - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_action_ctrl.sv
// Randomized self-checking bench for board_action_ctrl against a transaction-level board model.
module tb_board_action_ctrl;

    localparam int COLS  = 8;
    localparam int ROWS  = 8;
    localparam int MINES = 10;

    logic       clk = 1'b0;
    logic       reset, new_game;
    logic       mv_up, mv_dn, mv_lf, mv_rt, req_flag, req_reveal;
    logic [5:0] ram_addr, addr_w;
    logic [7:0] ram_rdata, ram_wdata, rdata_w, wdata_w;
    logic       ram_we, we_w;
    logic [3:0] cur_x, cur_y, cx_w, cy_w;
    logic       busy, action_done, busy_w, done_w;
    logic [7:0] flags_left, flags_w;
    logic       game_over, win, go_w, win_w;

    logic [7:0] ram   [64];
    logic [7:0] ram_w [64];
    logic [7:0] board [64];

    int mx, my, m_flags, m_cnt;
    bit m_go, m_win;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_action_ctrl #(.COLS(COLS), .ROWS(ROWS), .MINES(MINES), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .mv_up(mv_up), .mv_dn(mv_dn), .mv_lf(mv_lf), .mv_rt(mv_rt),
        .req_flag(req_flag), .req_reveal(req_reveal),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .action_done(action_done),
        .flags_left(flags_left), .game_over(game_over), .win(win)
    );

    board_action_ctrl #(.COLS(COLS), .ROWS(ROWS), .MINES(63), .ADDR_W(6)) dut_w (
        .clk(clk), .reset(reset), .new_game(new_game),
        .mv_up(mv_up), .mv_dn(mv_dn), .mv_lf(mv_lf), .mv_rt(mv_rt),
        .req_flag(req_flag), .req_reveal(req_reveal),
        .ram_addr(addr_w), .ram_rdata(rdata_w), .ram_we(we_w), .ram_wdata(wdata_w),
        .cur_x(cx_w), .cur_y(cy_w), .busy(busy_w), .action_done(done_w),
        .flags_left(flags_w), .game_over(go_w), .win(win_w)
    );

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
        if (we_w) ram_w[addr_w] <= wdata_w;
        rdata_w <= ram_w[addr_w];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; m_flags = MINES; m_cnt = 0; m_go = 0; m_win = 0;
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        ram[a]   <= v;
        board[a] = v;
    endtask

    function automatic logic [7:0] rand_cell();
        logic [7:0] c;
        c      = 8'($urandom);
        c[7]   = ($urandom_range(7) == 0);
        c[6]   = ($urandom_range(7) == 0);
        c[5]   = ($urandom_range(5) == 0);
        c[3:0] = 4'($urandom_range(8));
        return c;
    endfunction

    // mv = {up, dn, lf, rt}; inputs are held across one rising edge.
    task automatic step(input logic [3:0] mv, input logic rf, input logic rr);
        {mv_up, mv_dn, mv_lf, mv_rt} = mv;
        req_flag   = rf;
        req_reveal = rr;
        @(negedge clk);
        {mv_up, mv_dn, mv_lf, mv_rt} = 4'b0000;
        req_flag   = 1'b0;
        req_reveal = 1'b0;
    endtask

    task automatic apply_move(input logic [3:0] mv);
        if (mv[0] && !mv[1] && mx < COLS - 1) mx++;
        if (mv[1] && !mv[0] && mx > 0)        mx--;
        if (mv[2] && !mv[3] && my < ROWS - 1) my++;
        if (mv[3] && !mv[2] && my > 0)        my--;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_flags"}, 32'(flags_left), m_flags);
        check_val({tag, "_go"}, 32'(game_over), 32'(m_go));
        check_val({tag, "_win"}, 32'(win), 32'(m_win));
    endtask

    task automatic do_io(input logic [3:0] mv, input logic rf, input logic rr);
        int         a, we_seen;
        logic [7:0] c, exp_wd;
        bit         exp_we;
        if (!((rf || rr) && !m_go && !m_win)) begin
            step(mv, rf, rr);
            apply_move(mv);
            check_val("cur_x", 32'(cur_x), mx);
            check_val("cur_y", 32'(cur_y), my);
            check_val("idle_busy", 32'(busy), 0);
            check_val("idle_we", 32'(ram_we), 0);
            check_val("idle_done", 32'(action_done), 0);
        end else begin
            a = my * COLS + mx;
            check_val("ram_addr", 32'(ram_addr), a);
            c      = board[a];
            exp_we = 0;
            exp_wd = c;
            if (rr) begin
                if (!c[5] && !c[6]) begin
                    exp_we = 1; exp_wd[6] = 1'b1;
                    if (c[7]) m_go = 1;
                    else begin
                        m_cnt++;
                        if (m_cnt == ROWS * COLS - MINES) m_win = 1;
                    end
                end
            end else if (!c[6]) begin
                if (c[5]) begin
                    exp_we = 1; exp_wd[5] = 1'b0; m_flags++;
                end else if (m_flags > 0) begin
                    exp_we = 1; exp_wd[5] = 1'b1; m_flags--;
                end
            end
            if (exp_we) board[a] = exp_wd;
            step(mv, rf, rr);
            we_seen = 0;
            for (int t = 1; t <= 4; t++) begin
                check_val("act_busy", 32'(busy), 1);
                check_val("act_done", 32'(action_done), 32'(t == 4));
                if (ram_we) begin
                    we_seen++;
                    check_val("we_cycle", t, 3);
                    check_val("wdata", 32'(ram_wdata), 32'(exp_wd));
                end
                if (t == 4) check_status("done");
                step(4'($urandom), 1'($urandom), 1'($urandom));
            end
            check_val("end_busy", 32'(busy), 0);
            check_val("end_done", 32'(action_done), 0);
            check_val("we_count", we_seen, 32'(exp_we));
            check_val("hold_x", 32'(cur_x), mx);
            check_val("hold_y", 32'(cur_y), my);
            check_val("ram_cell", 32'(ram[a]), 32'(board[a]));
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        check_val("ng_x", 32'(cur_x), 0);
        check_val("ng_y", 32'(cur_y), 0);
        check_val("ng_busy", 32'(busy), 0);
        check_status("ng");
    endtask

    initial begin
        logic [3:0] mv;
        logic       rf, rr;
        reset = 1'b1; new_game = 1'b0;
        {mv_up, mv_dn, mv_lf, mv_rt} = 4'b0000;
        req_flag = 1'b0; req_reveal = 1'b0;
        for (int i = 0; i < 64; i++) begin
            poke(i, 8'h00);
            ram_w[i] <= 8'h00;
        end
        repeat (3) @(negedge clk);
        model_reset();
        check_val("rst_x", 32'(cur_x), 0);
        check_val("rst_y", 32'(cur_y), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(action_done), 0);
        check_val("rst_we", 32'(ram_we), 0);
        check_val("rst_wdata", 32'(ram_wdata), 0);
        check_status("rst");
        check_val("rst_flags_w", 32'(flags_w), 63);
        check_val("rst_win_w", 32'(win_w), 0);
        reset = 1'b0;

        repeat (9) do_io(4'b0001, 0, 0);
        repeat (9) do_io(4'b0100, 0, 0);
        check_val("clamp_x", 32'(cur_x), 7);
        check_val("clamp_y", 32'(cur_y), 7);
        do_io(4'b0011, 0, 0);
        check_val("cancel_x", 32'(cur_x), 7);
        repeat (5) do_io(4'b0010, 0, 0);
        repeat (4) do_io(4'b1000, 0, 0);
        check_val("addr26", 32'(ram_addr), 26);

        do_io(4'b0000, 1, 0);
        check_val("flag_set", 32'(flags_left), 9);
        do_io(4'b0000, 1, 0);
        check_val("flag_clr", 32'(flags_left), 10);
        repeat (10) begin
            poke(26, 8'h00);
            do_io(4'b0000, 1, 0);
        end
        check_val("flags_zero", 32'(flags_left), 0);
        poke(26, 8'h00);
        do_io(4'b0000, 1, 0);
        poke(26, 8'h20);
        do_io(4'b0101, 1, 0);

        do_new_game();
        poke(0, 8'h03);
        do_io(4'b0000, 1, 1);
        check_val("both_flags", 32'(flags_left), 10);
        do_io(4'b0001, 0, 0);
        poke(1, 8'h80);
        do_io(4'b0000, 0, 1);
        check_val("mine_go", 32'(game_over), 1);
        do_io(4'b0000, 0, 1);
        do_io(4'b0000, 1, 0);
        do_new_game();

        do_io(4'b0101, 0, 0);
        poke(9, 8'h05);
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_we", 32'(ram_we), 0);
        check_val("abort_wdata", 32'(ram_wdata), 0);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_done", 32'(action_done), 0);
        check_val("abort_x", 32'(cur_x), 0);
        check_val("abort_y", 32'(cur_y), 0);
        reset = 1'b0;
        model_reset();
        check_status("abort");
        @(negedge clk);
        check_val("abort_cell", 32'(ram[9]), 32'h05);

        for (int i = 0; i < 64; i++) poke(i, rand_cell());
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(14) == 0) begin
                do_new_game();
                for (int i = 0; i < 64; i++) poke(i, rand_cell());
            end else begin
                mv = {($urandom_range(3) == 0), ($urandom_range(3) == 0),
                      ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
                rf = ($urandom_range(3) == 0);
                rr = ($urandom_range(4) == 0);
                if ((rf || rr) && (m_go || m_win)) mv = 4'b0000;
                do_io(mv, rf, rr);
            end
        end

        do_new_game();
        poke(0, 8'h01);
        ram_w[0] <= 8'h01;
        do_io(4'b0000, 0, 1);
        check_val("win_w", 32'(win_w), 1);
        check_val("win_w_go", 32'(go_w), 0);
        check_val("win_main", 32'(win), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
